// File: rtl/mux_pkg.sv
// Shared constants and helpers for the parametrised operand selectors.
package mux_pkg;

  localparam int MUX_MAX_N     = 16;
  localparam int DEFAULT_WIDTH = 32;

  // Select width for an n-input mux, never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_n.sv
// Combinational N-to-1 selector with out-of-range detection; zero latency.
// No flow control: the output follows sel/in_flat directly.
module mux_n
  import mux_pkg::*;
#(
  parameter int              WIDTH       = DEFAULT_WIDTH,
  parameter int              N           = 4,
  parameter logic [WIDTH-1:0] DEFAULT_VAL = '0,
  localparam int             SEL_W       = sel_width(N)
) (
  input  logic [N*WIDTH-1:0] in_flat,
  input  logic [SEL_W-1:0]   sel,
  output logic [WIDTH-1:0]   data,
  output logic               sel_oob
);

  // Any select not matching a real input falls through to the default value.
  always_comb begin
    data    = DEFAULT_VAL;
    sel_oob = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (sel == SEL_W'(k)) begin
        data    = in_flat[k*WIDTH +: WIDTH];
        sel_oob = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_n_buf.sv
// N-input selector feeding a 2-entry valid/ready buffer; 1-cycle latency, 1 transfer/cycle.
// in_ready depends only on occupancy, so a full buffer refills one cycle after a pop.
module mux_n_buf
  import mux_pkg::*;
#(
  parameter int              WIDTH       = DEFAULT_WIDTH,
  parameter int              N           = 4,
  parameter logic [WIDTH-1:0] DEFAULT_VAL = '0,
  localparam int             SEL_W       = sel_width(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_flat,
  input  logic [SEL_W-1:0]   sel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               sel_err,
  input  logic               clr_err
);

  if (N < 2 || N > MUX_MAX_N) begin : g_bad_n
    $error("mux_n_buf: N out of range");
  end

  logic [WIDTH-1:0] mux_dat;
  logic             mux_oob;
  logic [WIDTH-1:0] entry [2];
  logic [1:0]       count;
  logic             wr_ptr;
  logic             rd_ptr;
  logic             push;
  logic             pop;

  mux_n #(
    .WIDTH       (WIDTH),
    .N           (N),
    .DEFAULT_VAL (DEFAULT_VAL)
  ) u_mux (
    .in_flat (in_flat),
    .sel     (sel),
    .data    (mux_dat),
    .sel_oob (mux_oob)
  );

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign out       = entry[rd_ptr];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry[0] <= '0;
      entry[1] <= '0;
      count    <= 2'd0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      sel_err  <= 1'b0;
    end else begin
      if (push) begin
        entry[wr_ptr] <= mux_dat;
        wr_ptr        <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
      // A new error outranks a clear arriving in the same cycle.
      if (push && mux_oob) begin
        sel_err <= 1'b1;
      end else if (clr_err) begin
        sel_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_n_buf.sv
// Scoreboard bench for mux_n_buf: an N=4 instance and an N=5 instance with DEFAULT_VAL=0xDEAD.
module tb_mux_n_buf;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  inv [5];
  logic [159:0] in_flat;
  logic [1:0]   sel0;
  logic [2:0]   sel1;
  logic [1:0]   in_valid, in_ready, out_valid, out_ready, sel_err, clr_err;
  logic [31:0]  dout0, dout1;

  int checks = 0;
  int passes = 0;
  int occ [2];
  bit err [2];
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];

  assign in_flat = {inv[4], inv[3], inv[2], inv[1], inv[0]};

  always #5 clk = ~clk;

  mux_n_buf #(.WIDTH(32), .N(4), .DEFAULT_VAL(32'h0)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_flat(in_flat[127:0]), .sel(sel0),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .out(dout0),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .sel_err(sel_err[0]), .clr_err(clr_err[0])
  );

  mux_n_buf #(.WIDTH(32), .N(5), .DEFAULT_VAL(32'hDEAD)) dut5 (
    .clk(clk), .rst_n(rst_n), .in_flat(in_flat), .sel(sel1),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .out(dout1),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .sel_err(sel_err[1]), .clr_err(clr_err[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Monitors: pop the expected value whenever a handshake is about to complete.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid[0] === 1'b1 && out_ready[0] === 1'b1) begin
      if (q0.size() == 0) check("n4_underflow", 32'd1, 32'd0);
      else check("n4_data", dout0, q0.pop_front());
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid[1] === 1'b1 && out_ready[1] === 1'b1) begin
      if (q1.size() == 0) check("n5_underflow", 32'd1, 32'd0);
      else check("n5_data", dout1, q1.pop_front());
    end
  end

  // One clock of the reference model: occupancy counting plus sticky error.
  task automatic step();
    int  nn, s;
    bit  acc, pop;
    logic [31:0] exp;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      nn  = (d == 0) ? 4 : 5;
      s   = (d == 0) ? int'(sel0) : int'(sel1);
      acc = in_valid[d] && (occ[d] != 2);
      pop = out_ready[d] && (occ[d] != 0);
      check(d == 0 ? "n4_in_ready" : "n5_in_ready", 32'(in_ready[d]), 32'(occ[d] != 2));
      check(d == 0 ? "n4_out_valid" : "n5_out_valid", 32'(out_valid[d]), 32'(occ[d] != 0));
      check(d == 0 ? "n4_sel_err" : "n5_sel_err", 32'(sel_err[d]), 32'(err[d]));
      if (acc) begin
        exp = (s < nn) ? inv[s] : ((d == 0) ? 32'h0 : 32'hDEAD);
        if (d == 0) q0.push_back(exp);
        else q1.push_back(exp);
      end
      occ[d] = occ[d] + int'(acc) - int'(pop);
      if (acc && s >= nn) err[d] = 1'b1;
      else if (clr_err[d]) err[d] = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    occ[0] = 0; occ[1] = 0;
    err[0] = 1'b0; err[1] = 1'b0;
    q0.delete(); q1.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    inv[0] = 32'h11; inv[1] = 32'h22; inv[2] = 32'h33; inv[3] = 32'h44; inv[4] = 32'h55;
    sel0 = '0; sel1 = '0;
    in_valid = '0; out_ready = '0; clr_err = '0;
    model_reset();
    #2;
    check("rst_in_ready", 32'(in_ready), 32'b11);
    check("rst_out_valid", 32'(out_valid), 32'b00);
    check("rst_out4", dout0, 32'h0);
    check("rst_out5", dout1, 32'h0);
    check("rst_sel_err", 32'(sel_err), 32'b00);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Back-to-back pushes with the consumer always ready.
    out_ready[0] = 1'b1; in_valid[0] = 1'b1; sel0 = 2'd2;
    step();
    check("lat_out", dout0, 32'h33);
    check("lat_vld", 32'(out_valid[0]), 32'd1);
    sel0 = 2'd0;
    step();
    check("tput_out", dout0, 32'h11);
    in_valid[0] = 1'b0;
    step(); step();

    // Fill while stalled; third offer must wait.
    out_ready[0] = 1'b0; in_valid[0] = 1'b1; sel0 = 2'd1;
    step();
    sel0 = 2'd3;
    step();
    sel0 = 2'd0;
    step();
    check("full_in_ready", 32'(in_ready[0]), 32'd0);
    out_ready[0] = 1'b1;
    step(); step();
    in_valid[0] = 1'b0;
    step(); step();

    // Simultaneous push and pop at one entry.
    out_ready[0] = 1'b0; in_valid[0] = 1'b1; sel0 = 2'd1;
    step();
    out_ready[0] = 1'b1; sel0 = 2'd3;
    step();
    check("simul_out", dout0, 32'h44);
    check("simul_vld", 32'(out_valid[0]), 32'd1);
    in_valid[0] = 1'b0;
    step(); step();

    // Out-of-range select, sticky error, clear, and set-over-clear.
    out_ready[1] = 1'b1; in_valid[1] = 1'b1; sel1 = 3'd6;
    step();
    check("oob_out", dout1, 32'hDEAD);
    check("oob_err", 32'(sel_err[1]), 32'd1);
    sel1 = 3'd4;
    step();
    check("legal_out", dout1, 32'h55);
    in_valid[1] = 1'b0; clr_err[1] = 1'b1;
    step();
    clr_err[1] = 1'b0;
    check("clr_err", 32'(sel_err[1]), 32'd0);
    in_valid[1] = 1'b1; clr_err[1] = 1'b1; sel1 = 3'd7;
    step();
    check("set_wins", 32'(sel_err[1]), 32'd1);
    in_valid[1] = 1'b0; clr_err[1] = 1'b0;
    step();

    // Asynchronous reset with data buffered and an error pending.
    out_ready = 2'b00; in_valid = 2'b11; sel0 = 2'd2; sel1 = 3'd1;
    step();
    in_valid = 2'b00;
    #3 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'b00);
    check("arst_in_ready", 32'(in_ready), 32'b11);
    check("arst_out4", dout0, 32'h0);
    check("arst_out5", dout1, 32'h0);
    check("arst_sel_err", 32'(sel_err), 32'b00);
    model_reset();
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // Randomized traffic on both instances.
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < 5; k++) inv[k] = $urandom;
      sel0      = 2'($urandom_range(0, 3));
      sel1      = 3'($urandom_range(0, 7));
      in_valid  = 2'($urandom_range(0, 3));
      out_ready = 2'($urandom_range(0, 3));
      clr_err   = {($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0)};
      step();
    end

    in_valid = 2'b00; out_ready = 2'b11; clr_err = 2'b00;
    step(); step(); step();
    check("drain_q4", q0.size(), 32'd0);
    check("drain_q5", q1.size(), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mux_n_buf.md
Name: mux_n_buf

Overview:
- Parametrised N-input, WIDTH-bit selector. Generalises the 4-way combinational operand mux.
- Registers its selected result into a 2-entry output buffer with valid/ready handshakes on both sides.
- Flags out-of-range selects and substitutes a default value for them.
- Sits between datapath sources (regfile/stack top, ALU, memory data, immediates) and multicycle consumers that may stall.

Parameters:
- WIDTH, 32, data width of each input and of the output.
- N, 4, number of data inputs; legal range 2..16.
- SEL_W, $clog2(N), select width; derived, never overridden.
- DEFAULT_VAL, 0, value emitted when sel >= N.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_flat  in  N*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH].
- sel  in  SEL_W  input select; sampled only on an accepted transfer.
- in_valid  in  1  producer has a valid sel/in_flat this cycle.
- in_ready  out  1  buffer can accept this cycle.
- out  out  WIDTH  head-of-buffer data.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  consumer takes the head this cycle.
- sel_err  out  1  sticky flag: an out-of-range select was accepted.
- clr_err  in  1  synchronous clear of sel_err.

Behaviour:
- Reset (rst_n low, async):
  - count=0, wr_ptr=0, rd_ptr=0.
  - Both entries = 0, so out=0.
  - out_valid=0, sel_err=0.
  - No capture while rst_n is low.
- in_ready = (count != 2). It depends only on registered state, never on out_ready; no combinational path in->out.
- out_valid = (count != 0). out = entry[rd_ptr] at all times, so data is stale when out_valid=0.
- Push: in_valid && in_ready.
  - entry[wr_ptr] <= (sel < N) ? in_flat[sel] : DEFAULT_VAL.
  - wr_ptr toggles.
- Pop: out_valid && out_ready. rd_ptr toggles.
- count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push and pop, which is only possible at count=1.
- Latency: data accepted at edge T is visible with out_valid=1 after edge T, i.e. 1 cycle.
- Throughput: 1 transfer/cycle sustained when out_ready is held high.
- Full (count=2): in_ready=0. A pop in that cycle frees a slot; in_ready rises the next cycle. No same-cycle refill.
- Empty (count=0): pop impossible, since out_valid=0. Push proceeds normally.
- Pointer wrap: 1-bit pointers toggle 0->1->0.
- Out-of-range select (sel >= N, only possible when N is not a power of 2):
  - The entry gets DEFAULT_VAL.
  - sel_err is set on that push.
  - Non-accepted cycles never set sel_err.
- Error clear/set priority: when clr_err and a new error push occur in the same cycle, set wins and sel_err=1. clr_err alone clears sel_err next cycle.
- Producer obligation: hold sel/in_flat stable while in_valid=1 && in_ready=0. The block does not check this.
- Reset mid-transfer: all buffered entries are discarded. out_valid drops immediately (async) and pending sel_err is lost.

Decomposition:
- Shared package mux_pkg:
  - MUX_MAX_N=16.
  - Function sel_width(n) returning max(1, clog2(n)).
  - Localparam DEFAULT_WIDTH=32.
- Sub-module mux_n: purely combinational N-to-1 mux over in_flat, plus the range check. Outputs data and sel_oob.
- mux_n_buf instantiates one mux_n and adds the 2-entry buffer, count/pointer logic and the sticky flag.

Test Plan:
- Reset then idle:
  - Expect in_ready=1, out_valid=0, out=0, sel_err=0.
  - Assert rst_n low mid-cycle; all outputs must clear without a clock edge.
- N=4, WIDTH=32, inputs 0x11,0x22,0x33,0x44, out_ready=1, push sel=2 then sel=0:
  - out=0x33 with out_valid the cycle after the first push.
  - Then out=0x22... correction: then out=0x11, giving one result per cycle.
- out_ready=0, push sel=1, sel=3, then offer sel=0:
  - count=2 and in_ready=0 on the third cycle; sel=0 is not accepted.
  - Raise out_ready: pops 0x22, then 0x44. Then sel=0 is accepted and 0x11 follows.
- Count=1 with simultaneous push(sel=3) and pop:
  - count stays 1.
  - Next cycle out=0x44, out_valid=1.
- N=5, DEFAULT_VAL=0xDEAD, push sel=6:
  - out=0xDEAD and sel_err=1 after the edge.
  - Push sel=4 (legal): sel_err stays 1.
  - Pulse clr_err: sel_err=0.
- N=5, clr_err asserted in the same cycle as a sel=7 push:
  - sel_err=1 (set wins).
